// File: rtl/clocktree_gen_param.sv
// Parametrised clock tree: NUM_CH register-generated divided clocks with
// runtime divisors, aligned launch and glitch-free (never-truncated) stops.
module clocktree_gen_param #(
    parameter int NUM_CH = 8,
    parameter int DIV_W  = 16,
    parameter int SEL_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start,
    input  logic              cfg_we_i,
    input  logic [SEL_W-1:0]  cfg_sel_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } ch_state_e;

    ch_state_e        state_q [NUM_CH];
    ch_state_e        state_d [NUM_CH];
    logic [DIV_W-1:0] cnt_q   [NUM_CH];
    logic [DIV_W-1:0] cnt_d   [NUM_CH];
    logic [DIV_W-1:0] act_q   [NUM_CH];
    logic [DIV_W-1:0] act_d   [NUM_CH];
    logic [DIV_W-1:0] shd_q   [NUM_CH];
    logic [DIV_W-1:0] shd_d   [NUM_CH];
    logic [DIV_W-1:0] nxt_cnt [NUM_CH];

    logic [NUM_CH-1:0] clk_q;
    logic [NUM_CH-1:0] clk_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] nxt_hi;
    logic              busy_q;
    logic              busy_d;
    logic              all_idle;
    logic              launch;

    // Reset divisor 2^(k+1), truncated to DIV_W and clamped to 2.
    function automatic logic [DIV_W-1:0] def_div(input int k);
        logic [63:0] v;
        v = 64'd1 << (k + 1);
        if (v[DIV_W-1:0] < DIV_W'(2)) begin
            return DIV_W'(2);
        end
        return v[DIV_W-1:0];
    endfunction

    always_comb begin
        all_idle = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (state_q[k] != ST_IDLE) begin
                all_idle = 1'b0;
            end
        end
        launch = start & all_idle;
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            nxt_cnt[k] = cnt_q[k] + DIV_W'(1);
            wrap[k]    = (cnt_q[k] == act_q[k] - DIV_W'(1));
            nxt_hi[k]  = (nxt_cnt[k] < (act_q[k] >> 1));
        end
    end

    always_comb begin
        busy_d = 1'b0;
        clk_d  = clk_q;
        tick_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            act_d[k]   = act_q[k];
            shd_d[k]   = shd_q[k];

            if (cfg_we_i && (cfg_sel_i == SEL_W'(k))) begin
                shd_d[k] = (cfg_div_i < DIV_W'(2)) ? DIV_W'(2) : cfg_div_i;
            end

            unique case (state_q[k])
                ST_IDLE: begin
                    if (launch) begin
                        state_d[k] = ST_RUN;
                        cnt_d[k]   = '0;
                        act_d[k]   = shd_q[k];
                        clk_d[k]   = 1'b1;
                        tick_d[k]  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!start && !clk_q[k]) begin
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = '0;
                        clk_d[k]   = 1'b0;
                    end else if (!start) begin
                        // High phase in progress: let it finish before idling.
                        if (!nxt_hi[k]) begin
                            state_d[k] = ST_IDLE;
                            cnt_d[k]   = '0;
                            clk_d[k]   = 1'b0;
                        end else begin
                            state_d[k] = ST_DRAIN;
                            cnt_d[k]   = nxt_cnt[k];
                        end
                    end else if (wrap[k]) begin
                        cnt_d[k]  = '0;
                        act_d[k]  = shd_q[k];
                        clk_d[k]  = 1'b1;
                        tick_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = nxt_cnt[k];
                        clk_d[k] = nxt_hi[k];
                    end
                end
                ST_DRAIN: begin
                    if (!nxt_hi[k]) begin
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = '0;
                        clk_d[k]   = 1'b0;
                    end else begin
                        cnt_d[k] = nxt_cnt[k];
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                    cnt_d[k]   = '0;
                    clk_d[k]   = 1'b0;
                end
            endcase

            if (state_d[k] != ST_IDLE) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
                act_q[k]   <= def_div(k);
                shd_q[k]   <= def_div(k);
            end
            clk_q  <= '0;
            tick_q <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                act_q[k]   <= act_d[k];
                shd_q[k]   <= shd_d[k];
            end
            clk_q  <= clk_d;
            tick_q <= tick_d;
            busy_q <= busy_d;
        end
    end

    assign clk_out = clk_q;
    assign tick_o  = tick_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_clocktree_gen_param.sv
// Bench for clocktree_gen_param: directed scenarios plus random traffic,
// checked each cycle against a period/phase reference model.
module tb_clocktree_gen_param;

    localparam int NUM_CH = 8;
    localparam int DIV_W  = 16;
    localparam int SEL_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              cfg_we;
    logic [SEL_W-1:0]  cfg_sel;
    logic [DIV_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick_o;
    logic              busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clocktree_gen_param #(
        .NUM_CH (NUM_CH),
        .DIV_W  (DIV_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start     (start),
        .cfg_we_i  (cfg_we),
        .cfg_sel_i (cfg_sel),
        .cfg_div_i (cfg_div),
        .clk_out   (clk_out),
        .tick_o    (tick_o),
        .busy_o    (busy_o)
    );

    // Model: each live channel sits at phase pos within a period of m_d cycles.
    int                m_pos [NUM_CH];
    int                m_d   [NUM_CH];
    int                m_sh  [NUM_CH];
    bit                m_live  [NUM_CH];
    bit                m_drain [NUM_CH];
    bit                m_launched;
    logic [NUM_CH-1:0] e_clk;
    logic [NUM_CH-1:0] e_tick;
    logic              e_busy;

    task automatic model_outputs();
        e_busy = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            e_clk[k] = m_live[k] && (m_pos[k] < m_d[k] / 2);
            if (m_live[k]) e_busy = 1'b1;
        end
    endtask

    task automatic model_reset();
        longint p;
        for (int k = 0; k < NUM_CH; k++) begin
            p = (longint'(1) << (k + 1)) % (longint'(1) << DIV_W);
            m_sh[k]    = (p < 2) ? 2 : int'(p);
            m_d[k]     = m_sh[k];
            m_pos[k]   = 0;
            m_live[k]  = 1'b0;
            m_drain[k] = 1'b0;
        end
        m_launched = 1'b0;
        e_tick     = '0;
        model_outputs();
    endtask

    task automatic model_edge();
        bit any;
        any = 1'b0;
        for (int k = 0; k < NUM_CH; k++) if (m_live[k]) any = 1'b1;
        m_launched = start && !any;
        e_tick = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!m_live[k]) begin
                if (m_launched) begin
                    m_live[k]  = 1'b1;
                    m_drain[k] = 1'b0;
                    m_pos[k]   = 0;
                    m_d[k]     = m_sh[k];
                    e_tick[k]  = 1'b1;
                end
            end else begin
                if (!m_drain[k] && !start) begin
                    if (m_pos[k] < m_d[k] / 2) begin
                        m_drain[k] = 1'b1;
                    end else begin
                        m_live[k] = 1'b0;
                        m_pos[k]  = 0;
                    end
                end
                if (m_live[k] && m_drain[k]) begin
                    if (m_pos[k] + 1 >= m_d[k] / 2) begin
                        m_live[k]  = 1'b0;
                        m_drain[k] = 1'b0;
                        m_pos[k]   = 0;
                    end else begin
                        m_pos[k]++;
                    end
                end else if (m_live[k]) begin
                    if (m_pos[k] + 1 == m_d[k]) begin
                        m_pos[k]  = 0;
                        m_d[k]    = m_sh[k];
                        e_tick[k] = 1'b1;
                    end else begin
                        m_pos[k]++;
                    end
                end
            end
        end
        if (cfg_we && int'(cfg_sel) < NUM_CH) begin
            m_sh[cfg_sel] = (cfg_div < 2) ? 2 : int'(cfg_div);
        end
        model_outputs();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        cfg_we  = 1'b0;
        cfg_sel = '0;
        cfg_div = '0;
        model_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({clk_out, tick_o, busy_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got clk=%b tick=%b busy=%b, need all 0",
                     clk_out, tick_o, busy_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_launch();
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            n_chk++;
            if ({clk_out, tick_o, busy_o} !== {e_clk, e_tick, e_busy}) begin
                n_fail++;
                $display("FAIL launch c%0d: got %b/%b/%b need %b/%b/%b", c,
                         clk_out, tick_o, busy_o, e_clk, e_tick, e_busy);
            end
            if (c == 0) begin
                n_chk++;
                if (clk_out !== {NUM_CH{1'b1}} || busy_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL launch_aligned: got clk=%b busy=%b need all 1",
                             clk_out, busy_o);
                end
            end
        end
    endtask

    task automatic test_midperiod_write();
        for (int c = 0; c < 8 && m_pos[1] != 1; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        cfg_we  = 1'b1;
        cfg_sel = SEL_W'(1);
        cfg_div = DIV_W'(5);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            cfg_we = 1'b0;
            n_chk++;
            if ({clk_out, tick_o, busy_o} !== {e_clk, e_tick, e_busy}) begin
                n_fail++;
                $display("FAIL midwrite c%0d: got %b/%b/%b need %b/%b/%b", c,
                         clk_out, tick_o, busy_o, e_clk, e_tick, e_busy);
            end
        end
    endtask

    task automatic test_drain();
        int hi;
        hi = 0;
        for (int c = 0; c < 40 && m_pos[3] != 2; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            if (clk_out[3]) hi++;
            n_chk++;
            if ({clk_out, tick_o, busy_o} !== {e_clk, e_tick, e_busy}) begin
                n_fail++;
                $display("FAIL drain c%0d: got %b/%b/%b need %b/%b/%b", c,
                         clk_out, tick_o, busy_o, e_clk, e_tick, e_busy);
            end
        end
        n_chk++;
        if (hi != 5) begin
            n_fail++;
            $display("FAIL drain_ch3_high: got %0d cycles high, need 5", hi);
        end
    endtask

    task automatic test_restart_during_drain();
        int launches;
        launches = 0;
        start = 1'b1;
        for (int c = 0; c < 40 && !(m_live[3] && m_pos[3] == 2); c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        start = 1'b0;
        for (int c = 0; c < 310; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            if (c == 10) start = 1'b1;
            n_chk++;
            if ({clk_out, tick_o, busy_o} !== {e_clk, e_tick, e_busy}) begin
                n_fail++;
                $display("FAIL restart c%0d: got %b/%b/%b need %b/%b/%b", c,
                         clk_out, tick_o, busy_o, e_clk, e_tick, e_busy);
            end
            if (c > 10 && m_launched) begin
                launches++;
                n_chk++;
                if (clk_out !== {NUM_CH{1'b1}}) begin
                    n_fail++;
                    $display("FAIL relaunch_aligned: got clk=%b need all 1", clk_out);
                end
            end
        end
        n_chk++;
        if (launches != 1) begin
            n_fail++;
            $display("FAIL relaunch_count: got %0d launches, need 1", launches);
        end
    endtask

    task automatic test_clamp_and_badsel();
        start = 1'b0;
        for (int c = 0; c < 300 && e_busy; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        for (int w = 0; w < 4; w++) begin
            cfg_we  = 1'b1;
            cfg_sel = (w < 2) ? SEL_W'(0) : SEL_W'(NUM_CH + 7 * (w - 2));
            cfg_div = (w < 2) ? DIV_W'(w) : DIV_W'(3 + w);
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
        cfg_we = 1'b0;
        start  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            n_chk++;
            if ({clk_out, tick_o, busy_o} !== {e_clk, e_tick, e_busy}) begin
                n_fail++;
                $display("FAIL clamp c%0d: got %b/%b/%b need %b/%b/%b", c,
                         clk_out, tick_o, busy_o, e_clk, e_tick, e_busy);
            end
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if ({clk_out, tick_o, busy_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got clk=%b tick=%b busy=%b, need all 0",
                     clk_out, tick_o, busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            n_chk++;
            if ({clk_out, tick_o, busy_o} !== {e_clk, e_tick, e_busy}) begin
                n_fail++;
                $display("FAIL post_reset c%0d: got %b/%b/%b need %b/%b/%b", c,
                         clk_out, tick_o, busy_o, e_clk, e_tick, e_busy);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(39) == 0) start = ~start;
            cfg_we  = ($urandom_range(5) == 0);
            cfg_sel = SEL_W'($urandom_range(11));
            cfg_div = DIV_W'($urandom_range(13));
            @(posedge clk);
            model_edge();
            @(negedge clk);
            n_chk++;
            if ({clk_out, tick_o, busy_o} !== {e_clk, e_tick, e_busy}) begin
                n_fail++;
                $display("FAIL random c%0d: got %b/%b/%b need %b/%b/%b", c,
                         clk_out, tick_o, busy_o, e_clk, e_tick, e_busy);
            end
        end
        cfg_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_launch();
        test_midperiod_write();
        test_drain();
        test_restart_during_drain();
        test_clamp_and_badsel();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
